// File: rtl/uc_metronomo.sv
// -----------------------------------------------------------------------------
// uc_metronomo
//   Control unit for a rhythm session. It sequences an external period counter
//   (contador_periodo, M cycles per beat) through NUM_BATIDAS beats, emits a
//   beat pulse at the start of each period, opens a hit window for the first
//   quarter of the period and judges player hits as acerto or erro, keeping
//   session tallies for the display logic.
//
// Ports
//   clock      in   system clock, all logic on posedge
//   reset      in   synchronous active-high reset
//   iniciar    in   start / resume request (1-cycle pulse)
//   pausar     in   pause request (1-cycle pulse)
//   jogada     in   player hit (1-cycle pulse, edge-detected upstream)
//   fim_antes  in   counter flag, Q == M/4-1 (end of hit window)
//   fim_depois in   counter flag, Q == M-1 (end of period)
//   zera_per   out  counter synchronous clear
//   conta_per  out  counter enable
//   batida     out  1-cycle pulse at each beat start
//   janela     out  hit window open
//   acerto     out  1-cycle pulse, hit on time
//   erro       out  1-cycle pulse, bad hit or missed beat
//   pronto     out  session finished
//   n_batidas  out  beats emitted this session
//   n_acertos  out  acertos this session
//   n_erros    out  erros this session
//   db_estado  out  current state encoding
// -----------------------------------------------------------------------------
module uc_metronomo #(
  parameter int NUM_BATIDAS = 16,
  parameter int W           = 5
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         iniciar,
  input  logic         pausar,
  input  logic         jogada,
  input  logic         fim_antes,
  input  logic         fim_depois,
  output logic         zera_per,
  output logic         conta_per,
  output logic         batida,
  output logic         janela,
  output logic         acerto,
  output logic         erro,
  output logic         pronto,
  output logic [W-1:0] n_batidas,
  output logic [W-1:0] n_acertos,
  output logic [W-1:0] n_erros,
  output logic [2:0]   db_estado
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] PREPARA  = 3'd1;
  localparam logic [2:0] CONTANDO = 3'd2;
  localparam logic [2:0] PAUSADO  = 3'd3;
  localparam logic [2:0] FIM      = 3'd4;

  localparam logic [W-1:0] NB_W   = W'(NUM_BATIDAS);
  localparam logic [W-1:0] UM_W   = W'(1);
  localparam logic [W-1:0] ZERO_W = W'(0);

  logic [2:0]   estado_q, estado_d;
  logic         fase1_q, fase1_d;
  logic         ja_jogou_q, ja_jogou_d;
  logic         batida_q, batida_d;
  logic         acerto_q, acerto_d;
  logic         erro_q, erro_d;
  logic         zera_q, zera_d;
  logic         conta_q, conta_d;
  logic         janela_q, janela_d;
  logic         pronto_q, pronto_d;
  logic [W-1:0] n_batidas_q, n_batidas_d;
  logic [W-1:0] n_acertos_q, n_acertos_d;
  logic [W-1:0] n_erros_q, n_erros_d;
  logic         fim_sessao_s;

  // Next-state, judgment and tally logic.
  always_comb begin
    estado_d     = estado_q;
    fase1_d      = fase1_q;
    ja_jogou_d   = ja_jogou_q;
    batida_d     = 1'b0;
    acerto_d     = 1'b0;
    erro_d       = 1'b0;
    n_batidas_d  = n_batidas_q;
    n_acertos_d  = n_acertos_q;
    n_erros_d    = n_erros_q;
    // The session ends on the last period boundary once every beat was emitted.
    fim_sessao_s = fim_depois & (n_batidas_q == NB_W);

    case (estado_q)
      IDLE: begin
        if (iniciar) estado_d = PREPARA;
        else         estado_d = IDLE;
      end
      PREPARA: begin
        estado_d    = CONTANDO;
        batida_d    = 1'b1;
        n_batidas_d = UM_W;
        n_acertos_d = ZERO_W;
        n_erros_d   = ZERO_W;
        fase1_d     = 1'b1;
        ja_jogou_d  = 1'b0;
      end
      CONTANDO: begin
        // In CONTANDO the window is exactly fase1.
        acerto_d = jogada & fase1_q & ~ja_jogou_q;
        // A jogada at the period end is a bad hit and replaces the miss erro.
        erro_d   = (jogada & ~acerto_d) | (fim_depois & ~ja_jogou_q & ~jogada);
        if (acerto_d) n_acertos_d = n_acertos_q + UM_W;
        else          n_acertos_d = n_acertos_q;
        if (erro_d)   n_erros_d = n_erros_q + UM_W;
        else          n_erros_d = n_erros_q;

        if (fim_sessao_s) estado_d = FIM;
        else if (pausar)  estado_d = PAUSADO;
        else              estado_d = CONTANDO;

        // A new period starts on every non-final boundary, even one that pauses.
        if (fim_depois && !fim_sessao_s) begin
          batida_d    = 1'b1;
          n_batidas_d = n_batidas_q + UM_W;
          fase1_d     = 1'b1;
          ja_jogou_d  = 1'b0;
        end else begin
          if (fim_antes) fase1_d = 1'b0;
          else           fase1_d = fase1_q;
          if (jogada)    ja_jogou_d = 1'b1;
          else           ja_jogou_d = ja_jogou_q;
        end
      end
      PAUSADO: begin
        if (iniciar) estado_d = CONTANDO;
        else         estado_d = PAUSADO;
      end
      FIM: begin
        if (iniciar) estado_d = PREPARA;
        else         estado_d = FIM;
      end
      default: begin
        estado_d = IDLE;
      end
    endcase

    // Moore outputs are decoded from the next state so they can be registered.
    zera_d   = (estado_d == IDLE) | (estado_d == PREPARA);
    conta_d  = (estado_d == CONTANDO);
    janela_d = (estado_d == CONTANDO) & fase1_d;
    pronto_d = (estado_d == FIM);
  end

  // State, flag, pulse and tally registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q    <= IDLE;
      fase1_q     <= 1'b0;
      ja_jogou_q  <= 1'b0;
      batida_q    <= 1'b0;
      acerto_q    <= 1'b0;
      erro_q      <= 1'b0;
      zera_q      <= 1'b1;
      conta_q     <= 1'b0;
      janela_q    <= 1'b0;
      pronto_q    <= 1'b0;
      n_batidas_q <= ZERO_W;
      n_acertos_q <= ZERO_W;
      n_erros_q   <= ZERO_W;
    end else begin
      estado_q    <= estado_d;
      fase1_q     <= fase1_d;
      ja_jogou_q  <= ja_jogou_d;
      batida_q    <= batida_d;
      acerto_q    <= acerto_d;
      erro_q      <= erro_d;
      zera_q      <= zera_d;
      conta_q     <= conta_d;
      janela_q    <= janela_d;
      pronto_q    <= pronto_d;
      n_batidas_q <= n_batidas_d;
      n_acertos_q <= n_acertos_d;
      n_erros_q   <= n_erros_d;
    end
  end

  assign zera_per  = zera_q;
  assign conta_per = conta_q;
  assign batida    = batida_q;
  assign janela    = janela_q;
  assign acerto    = acerto_q;
  assign erro      = erro_q;
  assign pronto    = pronto_q;
  assign n_batidas = n_batidas_q;
  assign n_acertos = n_acertos_q;
  assign n_erros   = n_erros_q;
  assign db_estado = estado_q;

endmodule
